cmd_scheduler: RTL and testbench

- Shares the game engine's single command port between N_SRC input requesters plus an internal gravity generator.
- Requesters are the UART decoder, buttons, switches and bar timer; each has a one-entry pending slot.
- A round-robin arbiter moves at most one pending slot per cycle into a QSIZE FIFO.
- The engine drains the FIFO with a valid/ready handshake, asserting out_ready while in WAIT.

---
 rtl/cmd_scheduler.sv | 171 +++++++++++++++++
 tb/tb_cmd_scheduler.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_scheduler.sv
// cmd_scheduler: shares the game engine's single command port between N_SRC
// external requesters and an internal gravity generator.
//
// Each requester owns a one-entry pending slot (slot N_SRC belongs to gravity).
// A round-robin arbiter moves at most one pending slot per cycle into a
// QSIZE-deep FIFO. The engine drains the FIFO with a valid/ready handshake.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   enable          gravity counts only while high
//   flush           one-cycle pulse clearing FIFO, slots, rr pointer, gravity
//   level           game level, shortens the gravity period
//   req_valid       per-source request pulse
//   req_cmd         4-bit command of source i at [4i+:4]; 0 means no command
//   out_valid       FIFO non-empty
//   out_cmd         FIFO head command (0 when empty)
//   out_ready       engine accepts the head this cycle
//   count           FIFO occupancy
//   drop_cnt        saturating count of lost requests (cleared by rst only)
module cmd_scheduler #(
  parameter int         N_SRC     = 4,
  parameter int         QSIZE     = 16,
  parameter int         BASE_TICK = 50_000_000,
  parameter int         STEP_TICK = 3_000_000,
  parameter int         MIN_TICK  = 5_000_000,
  parameter logic [3:0] CMD_DOWN  = 4'd3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     flush,
  input  logic [3:0]               level,
  input  logic [N_SRC-1:0]         req_valid,
  input  logic [4*N_SRC-1:0]       req_cmd,
  output logic                     out_valid,
  output logic [3:0]               out_cmd,
  input  logic                     out_ready,
  output logic [$clog2(QSIZE):0]   count,
  output logic [15:0]              drop_cnt
);

  localparam int NSLOT = N_SRC + 1;
  localparam int PW    = $clog2(QSIZE);
  localparam int CW    = PW + 1;
  localparam int RW    = $clog2(NSLOT);
  localparam int GW    = 40;

  // Gravity period with a signed wide subtraction so high levels cannot wrap.
  function automatic logic [GW-1:0] grav_period(input logic [3:0] lvl);
    logic signed [GW-1:0] raw;
    raw = GW'(BASE_TICK) - GW'(STEP_TICK) * $signed({{(GW-4){1'b0}}, lvl});
    if (raw < GW'(MIN_TICK)) raw = GW'(MIN_TICK);
    return $unsigned(raw);
  endfunction

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [RW:0] inc);
    logic [16:0] s;
    s = {1'b0, a} + 17'(inc);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [NSLOT-1:0] slot_vld_q, slot_vld_d;
  logic [3:0]       slot_cmd_q [NSLOT];
  logic [3:0]       slot_cmd_d [NSLOT];
  logic [RW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [3:0]       mem_q [QSIZE];
  logic [3:0]       mem_d [QSIZE];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic [GW-1:0]    grav_cnt_q, grav_cnt_d;

  logic             full, pop, pop_down, grav_tick;
  logic             gnt_vld;
  logic [RW-1:0]    gnt_idx, scan_idx;
  logic [RW:0]      drops;

  assign out_valid = (count_q != '0);
  assign out_cmd   = out_valid ? mem_q[rd_ptr_q] : 4'd0;
  assign count     = count_q;
  assign drop_cnt  = drop_cnt_q;

  always_comb begin
    full      = (count_q == CW'(QSIZE));
    pop       = out_valid && out_ready;
    pop_down  = pop && (out_cmd == CMD_DOWN);
    grav_tick = enable && (grav_cnt_q >= grav_period(level));

    // Round-robin search from rr_ptr; full is judged before this cycle's pop.
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    for (int k = 0; k < NSLOT; k++) begin
      scan_idx = RW'((int'(rr_ptr_q) + k) % NSLOT);
      if (!full && !gnt_vld && slot_vld_q[scan_idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan_idx;
      end
    end

    slot_vld_d = slot_vld_q;
    slot_cmd_d = slot_cmd_q;
    drops      = '0;
    if (gnt_vld) slot_vld_d[gnt_idx] = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (req_valid[i] && (req_cmd[4*i +: 4] != 4'd0)) begin
        // A slot granted this cycle frees up in time to take the new request.
        if (slot_vld_q[i] && !(gnt_vld && (gnt_idx == RW'(i)))) begin
          drops = drops + 1'b1;
        end else begin
          slot_vld_d[i] = 1'b1;
          slot_cmd_d[i] = req_cmd[4*i +: 4];
        end
      end
    end
    // Gravity ticks merge into an already pending gravity slot.
    if (grav_tick) begin
      slot_vld_d[N_SRC] = 1'b1;
      slot_cmd_d[N_SRC] = CMD_DOWN;
    end

    rr_ptr_d = rr_ptr_q;
    if (gnt_vld) rr_ptr_d = (gnt_idx == RW'(N_SRC)) ? '0 : gnt_idx + RW'(1);

    drop_cnt_d = sat_add16(drop_cnt_q, drops);
    grav_cnt_d = (!enable || grav_tick || pop_down) ? '0 : grav_cnt_q + GW'(1);

    mem_d = mem_q;
    if (gnt_vld) mem_d[wr_ptr_q] = slot_cmd_q[gnt_idx];
    wr_ptr_d = wr_ptr_q + PW'(gnt_vld);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(gnt_vld) - CW'(pop);

    // Flush wipes everything except the drop counter; its requests are ignored.
    if (flush) begin
      slot_vld_d = '0;
      rr_ptr_d   = '0;
      drop_cnt_d = drop_cnt_q;
      grav_cnt_d = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_vld_q <= '0;
      rr_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      grav_cnt_q <= '0;
    end else begin
      slot_vld_q <= slot_vld_d;
      rr_ptr_q   <= rr_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      grav_cnt_q <= grav_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    slot_cmd_q <= slot_cmd_d;
    mem_q      <= mem_d;
  end

endmodule

// File: tb/tb_cmd_scheduler.sv
// Testbench for cmd_scheduler with a small configuration (QSIZE=4,
// BASE_TICK=20, STEP_TICK=4, MIN_TICK=8). Expected commands are queued as
// stimulus is issued; a negedge monitor pops and compares on each handshake.
module tb_cmd_scheduler;

  localparam int N_SRC = 4;
  localparam int QSIZE = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               enable = 1'b0;
  logic               flush = 1'b0;
  logic [3:0]         level = 4'd0;
  logic [N_SRC-1:0]   req_valid = '0;
  logic [4*N_SRC-1:0] req_cmd = '0;
  logic               out_valid;
  logic [3:0]         out_cmd;
  logic               out_ready = 1'b0;
  logic [$clog2(QSIZE):0] count;
  logic [15:0]        drop_cnt;

  int total = 0;
  int bad = 0;
  logic [3:0] exp_q[$];

  cmd_scheduler #(
    .N_SRC(N_SRC), .QSIZE(QSIZE), .BASE_TICK(20), .STEP_TICK(4),
    .MIN_TICK(8), .CMD_DOWN(4'd3)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush), .level(level),
    .req_valid(req_valid), .req_cmd(req_cmd), .out_valid(out_valid),
    .out_cmd(out_cmd), .out_ready(out_ready), .count(count), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every accepted head must match the next expected command.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got %0d, expected no output", out_cmd);
      end else begin
        check("sb_order", int'(out_cmd), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    req_cmd = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic send(input int src, input logic [3:0] cmd);
    req_valid = '0;
    req_cmd = '0;
    req_valid[src] = 1'b1;
    req_cmd[4*src +: 4] = cmd;
    tick();
    req_valid = '0;
    req_cmd = '0;
  endtask

  task automatic wait_count(input int target, output int n);
    n = 0;
    while (int'(count) != target && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] t3_cmds [5];
    t3_cmds = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd6};

    // Reset state
    do_reset();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_cmd", int'(out_cmd), 0);
    check("rst_count", int'(count), 0);
    check("rst_drop", int'(drop_cnt), 0);

    // Single request: two-edge latency
    exp_q.push_back(4'd1);
    send(1, 4'd1);
    check("t1_valid_e0", int'(out_valid), 0);
    tick();
    check("t1_valid_e1", int'(out_valid), 1);
    check("t1_cmd", int'(out_cmd), 1);
    check("t1_count", int'(count), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t1_count_pop", int'(count), 0);
    check("t1_cmd_empty", int'(out_cmd), 0);

    // Simultaneous requests, then wrap from rr_ptr=4
    do_reset();
    out_ready = 1'b1;
    req_valid = 4'hF;
    req_cmd = {4'd6, 4'd5, 4'd2, 4'd1};
    exp_q.push_back(4'd1); exp_q.push_back(4'd2);
    exp_q.push_back(4'd5); exp_q.push_back(4'd6);
    tick();
    req_valid = '0;
    req_cmd = '0;
    repeat (8) tick();
    check("t2_count", int'(count), 0);
    check("t2_drop", int'(drop_cnt), 0);
    check("t2_sb_empty", exp_q.size(), 0);
    req_valid = 4'b1001;
    req_cmd = {4'd8, 8'd0, 4'd7};
    exp_q.push_back(4'd7); exp_q.push_back(4'd8);
    tick();
    req_valid = '0;
    req_cmd = '0;
    repeat (6) tick();
    check("t2_wrap_sb_empty", exp_q.size(), 0);
    // rr_ptr=1 after src0 alone: src2 must beat src0
    exp_q.push_back(4'd9);
    send(0, 4'd9);
    repeat (4) tick();
    req_valid = 4'b0101;
    req_cmd = {8'd0, 4'd11, 4'd0, 4'd10};
    exp_q.push_back(4'd11); exp_q.push_back(4'd10);
    tick();
    req_valid = '0;
    req_cmd = '0;
    repeat (6) tick();
    check("t2_rr_sb_empty", exp_q.size(), 0);
    out_ready = 1'b0;

    // Full FIFO and drop
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(t3_cmds[i]);
      send(2, t3_cmds[i]);
      tick();
      tick();
    end
    check("t3_count_full", int'(count), 4);
    check("t3_drop0", int'(drop_cnt), 0);
    send(2, 4'd7);
    check("t3_drop1", int'(drop_cnt), 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_count_after_pop", int'(count), 3);
    tick();
    check("t3_count_refill", int'(count), 4);
    out_ready = 1'b1;
    repeat (6) tick();
    out_ready = 1'b0;
    check("t3_count_drained", int'(count), 0);
    check("t3_sb_empty", exp_q.size(), 0);

    // Flush mid-operation (no reset: drop_cnt stays 1)
    level = 4'd0;
    enable = 1'b1;
    req_valid = 4'b0111;
    req_cmd = {4'd0, 4'd4, 4'd2, 4'd1};
    tick();
    req_valid = '0;
    req_cmd = '0;
    repeat (3) tick();
    check("t6_count3", int'(count), 3);
    req_valid = 4'b0011;
    req_cmd = {8'd0, 4'd6, 4'd5};
    tick();
    flush = 1'b1;
    req_valid = 4'b0001;
    req_cmd = {12'd0, 4'd7};
    tick();
    flush = 1'b0;
    req_valid = '0;
    req_cmd = '0;
    check("t6_count", int'(count), 0);
    check("t6_valid", int'(out_valid), 0);
    check("t6_cmd", int'(out_cmd), 0);
    check("t6_drop", int'(drop_cnt), 1);
    wait_valid(n);
    check("t6_grav_restart", n, 22);
    check("t6_first_cmd", int'(out_cmd), 3);
    check("t6_first_count", int'(count), 1);
    exp_q.push_back(4'd3);
    enable = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    out_ready = 1'b0;
    check("t6_drained", int'(count), 0);

    // Gravity period and merge
    do_reset();
    level = 4'd0;
    enable = 1'b1;
    wait_count(1, n);
    check("t4_first_period", n, 22);
    wait_count(2, n);
    check("t4_period_lvl0", n, 21);
    level = 4'd5;
    wait_count(3, n);
    check("t4_level_change", n, 9);
    wait_count(4, n);
    check("t4_period_floor", n, 9);
    repeat (40) tick();
    check("t5_count_full", int'(count), 4);
    check("t5_drop", int'(drop_cnt), 0);
    for (int i = 0; i < 5; i++) exp_q.push_back(4'd3);
    enable = 1'b0;
    out_ready = 1'b1;
    repeat (8) tick();
    out_ready = 1'b0;
    check("t5_drained", int'(count), 0);
    check("t5_sb_empty", exp_q.size(), 0);

    // Accepted DOWN from src1 restarts gravity
    do_reset();
    level = 4'd0;
    out_ready = 1'b1;
    enable = 1'b1;
    repeat (9) tick();
    exp_q.push_back(4'd3);
    send(1, 4'd3);
    tick();
    tick();
    wait_valid(n);
    check("t4_restart_gap", n, 22);
    check("t4_restart_cmd", int'(out_cmd), 3);
    exp_q.push_back(4'd3);
    enable = 1'b0;
    repeat (3) tick();
    out_ready = 1'b0;
    check("t4_restart_drained", int'(count), 0);

    check("final_sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
